// File: rtl/ser2par_loader.sv
// ser2par_loader: collects WIDTH qualified serial bits and presents the
// assembled word on `out` with a one-cycle `load` strobe.
// Optional build macro: PARITY_CHECK_EN adds a trailing even-parity bit,
// a PAR state and the parity_err output.
module ser2par_loader #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sin,
  input  logic                     sin_valid,
  input  logic                     clear,
  output logic [WIDTH-1:0]         out,
  output logic                     load,
  output logic                     busy,
`ifdef PARITY_CHECK_EN
  output logic                     parity_err,
`endif
  output logic [$clog2(WIDTH):0]   bit_cnt
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
`endif

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   sreg_reg, sreg_next;
  logic [WIDTH-1:0]   out_reg, out_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               load_reg, load_next;
  logic               perr_reg, perr_next;
  logic [WIDTH-1:0]   shifted;

  // Shift register contents after accepting the current sin bit.
  always_comb begin
    if (MSB_FIRST) shifted = {sreg_reg[WIDTH-2:0], sin};
    else           shifted = {sin, sreg_reg[WIDTH-1:1]};
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      sreg_reg  <= '0;
      out_reg   <= '0;
      cnt_reg   <= '0;
      load_reg  <= 1'b0;
      perr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      sreg_reg  <= sreg_next;
      out_reg   <= out_next;
      cnt_reg   <= cnt_next;
      load_reg  <= load_next;
      perr_reg  <= perr_next;
    end
  end

  // Next-state and next-value logic; clear overrides bit acceptance but
  // never cancels a load that the LOAD state is already issuing.
  always_comb begin
    state_next = state_reg;
    sreg_next  = sreg_reg;
    out_next   = out_reg;
    cnt_next   = cnt_reg;
    load_next  = 1'b0;
    perr_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (sin_valid) begin
          sreg_next  = shifted;
          cnt_next   = CNT_W'(1);
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (sin_valid) begin
          sreg_next = shifted;
          cnt_next  = cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
            state_next = PAR;
`else
            state_next = LOAD;
`endif
          end
        end
      end
`ifdef PARITY_CHECK_EN
      PAR: begin
        // bit_cnt stays at WIDTH here; the data word is not shifted.
        if (sin_valid) begin
          if ((^sreg_reg ^ sin) == 1'b0) begin
            state_next = LOAD;
          end else begin
            perr_next  = 1'b1;
            cnt_next   = '0;
            state_next = IDLE;
          end
        end
      end
`endif
      LOAD: begin
        out_next   = sreg_reg;
        load_next  = 1'b1;
        cnt_next   = '0;
        state_next = IDLE;
        // A bit arriving now starts the next word with no gap.
        if (sin_valid) begin
          sreg_next  = shifted;
          cnt_next   = CNT_W'(1);
          state_next = SHIFT;
        end
      end
      default: state_next = IDLE;
    endcase

    if (clear) begin
      state_next = IDLE;
      cnt_next   = '0;
      sreg_next  = sreg_reg;
      perr_next  = 1'b0;
    end
  end

  assign out     = out_reg;
  assign load    = load_reg;
  assign bit_cnt = cnt_reg;
`ifdef PARITY_CHECK_EN
  assign busy       = (state_reg == SHIFT) || (state_reg == PAR);
  assign parity_err = perr_reg;
`else
  assign busy = (state_reg == SHIFT);
  // perr_reg is never set without the parity feature.
  logic unused_perr;
  assign unused_perr = perr_reg;
`endif

endmodule

// File: tb/tb_ser2par_loader.sv
// Directed bench for ser2par_loader: one MSB-first and one LSB-first
// instance share the same stimulus; expected words are hand-computed.
module tb_ser2par_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sin = 1'b0;
  logic       sin_valid = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] out_m, out_l;
  logic       load_m, load_l, busy_m, busy_l;
  logic [2:0] cnt_m, cnt_l;
`ifdef PARITY_CHECK_EN
  logic       perr_m, perr_l;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ser2par_loader #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .clear(clear),
    .out(out_m), .load(load_m), .busy(busy_m),
`ifdef PARITY_CHECK_EN
    .parity_err(perr_m),
`endif
    .bit_cnt(cnt_m)
  );

  ser2par_loader #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .clear(clear),
    .out(out_l), .load(load_l), .busy(busy_l),
`ifdef PARITY_CHECK_EN
    .parity_err(perr_l),
`endif
    .bit_cnt(cnt_l)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Advance one edge, then settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sin = b;
    sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0;
    sin = 1'b0;
  endtask

  // Sends w[3] first; appends the even-parity bit in parity builds.
  task automatic send_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) send_bit(w[i]);
`ifdef PARITY_CHECK_EN
    send_bit(^w);
`endif
  endtask

  initial begin
    // Reset state, observed without any clock edge.
    #1;
    check("rst.out_m", out_m, 4'b0000);
    check("rst.load_m", load_m, 1'b0);
    check("rst.busy_m", busy_m, 1'b0);
    check("rst.cnt_m", cnt_m, 3'd0);
    tick();
    reset = 1'b0;

    // Word 1,0,1,1.
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check("a.cnt3", cnt_m, 3'd3);
    check("a.busy", busy_m, 1'b1);
    send_bit(1'b1);
`ifdef PARITY_CHECK_EN
    check("a.busy_par", busy_m, 1'b1);
    check("a.cnt_sat", cnt_m, 3'd4);
    send_bit(1'b1);
`endif
    check("a.noload_yet", load_m, 1'b0);
    tick();
    check("a.load_m", load_m, 1'b1);
    check("a.load_l", load_l, 1'b1);
    check("a.out_m", out_m, 4'b1011);
    check("a.out_l", out_l, 4'b1101);
    check("a.cnt0", cnt_m, 3'd0);
    tick();
    check("a.load_drop", load_m, 1'b0);
    check("a.out_hold", out_m, 4'b1011);

    // Back-to-back 0,0,1,1 then 0,1,0,0 with idle gaps inside word 2.
    send_word(4'b0011);
    send_bit(1'b0);
    check("b.load1", load_m, 1'b1);
    check("b.out1_m", out_m, 4'b0011);
    check("b.out1_l", out_l, 4'b1100);
    check("b.cnt_next", cnt_m, 3'd1);
    tick();
    check("b.gap_load", load_m, 1'b0);
    check("b.gap_busy", busy_m, 1'b1);
    send_bit(1'b1);
    tick();
    tick();
    check("b.hold_out", out_m, 4'b0011);
    check("b.hold_cnt", cnt_m, 3'd2);
    send_bit(1'b0);
    send_bit(1'b0);
`ifdef PARITY_CHECK_EN
    send_bit(1'b1);
`endif
    tick();
    check("b.load2", load_m, 1'b1);
    check("b.out2_m", out_m, 4'b0100);
    check("b.out2_l", out_l, 4'b0010);

    // Two bits, then clear together with a valid bit, then 1,1,1,0.
    tick();
    send_bit(1'b1); send_bit(1'b0);
    clear = 1'b1;
    send_bit(1'b1);
    clear = 1'b0;
    check("c.cnt_clr", cnt_m, 3'd0);
    check("c.busy_clr", busy_m, 1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    check("c.cnt3", cnt_m, 3'd3);
    check("c.noload", load_m, 1'b0);
    send_bit(1'b0);
`ifdef PARITY_CHECK_EN
    send_bit(1'b1);
`endif
    tick();
    check("c.load", load_m, 1'b1);
    check("c.out_m", out_m, 4'b1110);
    check("c.out_l", out_l, 4'b0111);

    // Asynchronous reset mid-word with out and the shift register non-zero.
    tick();
    send_bit(1'b1); send_bit(1'b1);
    #3 reset = 1'b1;
    #1;
    check("r.out", out_m, 4'b0000);
    check("r.load", load_m, 1'b0);
    check("r.busy", busy_m, 1'b0);
    check("r.cnt", cnt_m, 3'd0);
    #1 reset = 1'b0;
    tick();
    send_word(4'b0110);
    tick();
    check("r.after_out", out_m, 4'b0110);
    check("r.after_load", load_m, 1'b1);

`ifdef PARITY_CHECK_EN
    // Good parity loads; bad parity pulses parity_err and keeps out.
    tick();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b1);
    tick();
    check("p.good_load", load_m, 1'b1);
    check("p.good_out", out_m, 4'b1011);
    tick();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b0);
    check("p.err", perr_m, 1'b1);
    check("p.bad_noload", load_m, 1'b0);
    tick();
    check("p.err_drop", perr_m, 1'b0);
    check("p.bad_noload2", load_m, 1'b0);
    check("p.bad_out", out_m, 4'b1011);
    check("p.bad_busy", busy_m, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
